lcd_init_seq: RTL
=================

LCD_INIT_SEQ -- requirements
Module: lcd_init_seq

Interface
REQ-001 SHALL have parameter H_RES, default 240, panel columns written by the window and fill phases.
REQ-002 SHALL have parameter V_RES, default 320, panel rows written by the window and fill phases.
REQ-003 SHALL have parameter T_RST_LOW, default 5_000_000, number of cycles lcd_rst is held low (100 ms at 50 MHz).
REQ-004 SHALL have parameter T_RST_HIGH, default 2_500_000, number of cycles waited after lcd_rst rises.
REQ-005 SHALL have parameter T_SLPOUT, default 6_000_000, number of cycles waited after SLPOUT.
REQ-006 SHALL have parameter MADCTL, default 8'h60, the orientation byte sent after command 0x36.
REQ-007 SHALL have parameter BOOT_COLOR, default 16'hFFFF, the RGB565 colour used for the power-on fill.
REQ-008 SHALL have input sys_clk_50MHz, 1 bit, the single clock.
REQ-009 SHALL have input sys_rst, 1 bit, reset: asynchronous and active-high (fixed decision).
REQ-010 SHALL have input wr_done, 1 bit, a one-cycle pulse from the SPI writer meaning the current item is sent.
REQ-011 SHALL have input reinit, 1 bit, a one-cycle pulse requesting a full re-initialisation.
REQ-012 SHALL have input fill_req, 1 bit, a one-cycle pulse requesting a full-screen fill.
REQ-013 SHALL have input fill_color, 16 bits, the RGB565 colour, sampled on an accepted fill_req.
REQ-014 SHALL have output lcd_rst, 1 bit, the panel reset (active low).
REQ-015 SHALL have output init_data, 9 bits, where bit8 = 1 means data and bit8 = 0 means command.
REQ-016 SHALL have output en_write, 1 bit, meaning init_data is valid for the writer.
REQ-017 SHALL have output init_done, 1 bit, high only in DONE.
REQ-018 SHALL have output busy, 1 bit, high in every state except DONE.

Function
REQ-019 States SHALL be RST_LOW, RST_HIGH, SLPOUT, SLP_WAIT, CFG, WIN, FILL and DONE, encoded one-hot.
REQ-020 Each delay state SHALL last exactly its T_* cycles, using a counter that clears on state entry and exits when the count equals T-1.
REQ-021 In RST_LOW, lcd_rst SHALL be 0; it SHALL go to 1 on the edge that enters RST_HIGH, then hold 1 until reset or reinit.
REQ-022 SLPOUT SHALL write a single item, 9'h011.
REQ-023 CFG SHALL write this table in order: 036, {1,MADCTL}, 03A, 105, then the team's standard ST7789V porch/power/gamma list, ending with 021, 029.
REQ-024 WIN SHALL write 11 items: 02A, 100, 100, {1,(H_RES-1)[15:8]}, {1,(H_RES-1)[7:0]}, 02B, 100, 100, {1,(V_RES-1)[15:8]}, {1,(V_RES-1)[7:0]}, 02C.
REQ-025 FILL SHALL write 2*H_RES*V_RES items, alternating {1,color[15:8]} at even indices and {1,color[7:0]} at odd indices.
REQ-026 The FILL item counter SHALL be sized to hold 2*H_RES*V_RES without wrap, and no counter SHALL wrap inside any phase.
REQ-027 en_write SHALL be 1 exactly while in SLPOUT, CFG, WIN or FILL.
REQ-028 In those states, init_data SHALL present the current item index; it SHALL be 9'h000 in every other state.
REQ-029 The item index SHALL advance only on wr_done while en_write = 1, and wr_done at any other time SHALL be ignored.
REQ-030 init_data SHALL show the next item on the cycle after that wr_done.
REQ-031 The wr_done for the last item of a phase SHALL move the state on the next edge: SLPOUT->SLP_WAIT, CFG->WIN, WIN->FILL, FILL->DONE.
REQ-032 The other transitions SHALL be RST_LOW->RST_HIGH->SLPOUT, and SLP_WAIT->CFG.
REQ-033 The power-on fill SHALL use BOOT_COLOR.
REQ-034 In DONE, fill_req SHALL latch fill_color and enter WIN, so only the window and fill are re-sent and no reset or CFG is repeated.
REQ-035 fill_req while busy = 1 SHALL be ignored and SHALL NOT be queued.
REQ-036 reinit in any state SHALL enter RST_LOW on the next edge, drive lcd_rst to 0, clear all counters and select BOOT_COLOR.
REQ-037 reinit SHALL take priority over fill_req and over any wr_done in the same cycle.
REQ-038 init_done SHALL fall on the edge that leaves DONE.

Reset
REQ-039 While sys_rst = 1, the block SHALL hold RST_LOW with lcd_rst = 0, init_data = 9'h000, en_write = 0, init_done = 0, busy = 1, all counters at 0 and colour = BOOT_COLOR.
REQ-040 Assertion of sys_rst mid-phase SHALL abort immediately, with no completion of the current item.
REQ-041 After release, the full sequence SHALL restart from RST_LOW.

Verification
REQ-042 Power-on with H_RES=2, V_RES=2, T_*=4, and wr_done 3 cycles after each en_write item: lcd_rst low for exactly 4 cycles; item order 011, CFG table, the 11 WIN items, then FF FF FF FF FF FF FF FF; init_done rises after the 8th fill wr_done.
REQ-043 In DONE, fill_req with fill_color=F800: the items are WIN then F8,00 repeated 4 times; busy is 1 throughout and 0 after; lcd_rst stays 1.
REQ-044 fill_req pulsed during CFG and again during FILL: both are ignored; only one boot fill occurs and the colour is unchanged.
REQ-045 reinit coincident with a wr_done in mid-FILL: next cycle RST_LOW, lcd_rst = 0, en_write = 0; the full sequence then repeats using BOOT_COLOR.
REQ-046 Stray wr_done pulses during RST_HIGH and SLP_WAIT: no index change, and the first CFG item is still 036.
REQ-047 sys_rst asserted mid-WIN for 1 cycle: all outputs take their reset values asynchronously, and the sequence restarts from RST_LOW.

Source files
------------

// File: rtl/lcd_init_seq.sv
// ST7789V power-on sequencer: panel reset, SLPOUT, configuration table, address
// window and full-screen fill, streamed item by item to an SPI writer.
module lcd_init_seq #(
  parameter int unsigned H_RES      = 240,
  parameter int unsigned V_RES      = 320,
  parameter int unsigned T_RST_LOW  = 5_000_000,
  parameter int unsigned T_RST_HIGH = 2_500_000,
  parameter int unsigned T_SLPOUT   = 6_000_000,
  parameter logic [7:0]  MADCTL     = 8'h60,
  parameter logic [15:0] BOOT_COLOR = 16'hFFFF
) (
  input  logic        sys_clk_50MHz,
  input  logic        sys_rst,
  input  logic        wr_done,
  input  logic        reinit,
  input  logic        fill_req,
  input  logic [15:0] fill_color,
  output logic        lcd_rst,
  output logic [8:0]  init_data,
  output logic        en_write,
  output logic        init_done,
  output logic        busy
);

  localparam logic [7:0] S_RST_LOW  = 8'b0000_0001;
  localparam logic [7:0] S_RST_HIGH = 8'b0000_0010;
  localparam logic [7:0] S_SLPOUT   = 8'b0000_0100;
  localparam logic [7:0] S_SLP_WAIT = 8'b0000_1000;
  localparam logic [7:0] S_CFG      = 8'b0001_0000;
  localparam logic [7:0] S_WIN      = 8'b0010_0000;
  localparam logic [7:0] S_FILL     = 8'b0100_0000;
  localparam logic [7:0] S_DONE     = 8'b1000_0000;

  localparam int unsigned CFG_LEN  = 59;
  localparam int unsigned WIN_LEN  = 11;
  localparam int unsigned FILL_LEN = 2 * H_RES * V_RES;
  localparam int unsigned IDX_MAX  = (FILL_LEN > CFG_LEN) ? FILL_LEN : CFG_LEN;
  localparam int unsigned IDX_W    = $clog2(IDX_MAX + 1);
  localparam int unsigned T_MAX_A  = (T_RST_LOW > T_RST_HIGH) ? T_RST_LOW : T_RST_HIGH;
  localparam int unsigned T_MAX    = (T_MAX_A > T_SLPOUT) ? T_MAX_A : T_SLPOUT;
  localparam int unsigned DLY_W    = $clog2(T_MAX + 1);

  localparam logic [15:0] H_LAST = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST = 16'(V_RES - 1);

  // Porch, power and gamma settings ending with INVON / DISPON
  localparam logic [8:0] CFG_ROM [CFG_LEN] = '{
    9'h036, {1'b1, MADCTL}, 9'h03A, 9'h105,
    9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
    9'h0B7, 9'h135, 9'h0BB, 9'h119, 9'h0C0, 9'h12C, 9'h0C2, 9'h101,
    9'h0C3, 9'h112, 9'h0C4, 9'h120, 9'h0C6, 9'h10F, 9'h0D0, 9'h1A4, 9'h1A1,
    9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F,
    9'h154, 9'h14C, 9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
    9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F,
    9'h144, 9'h151, 9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
    9'h021, 9'h029
  };

  localparam logic [8:0] WIN_ROM [WIN_LEN] = '{
    9'h02A, 9'h100, 9'h100, {1'b1, H_LAST[15:8]}, {1'b1, H_LAST[7:0]},
    9'h02B, 9'h100, 9'h100, {1'b1, V_LAST[15:8]}, {1'b1, V_LAST[7:0]},
    9'h02C
  };

  logic [7:0]       state;
  logic [DLY_W-1:0] dly_cnt;
  logic [IDX_W-1:0] idx;
  logic [15:0]      color;

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= S_RST_LOW;
      lcd_rst <= 1'b0;
      dly_cnt <= '0;
      idx     <= '0;
      color   <= BOOT_COLOR;
    end else if (reinit) begin
      state   <= S_RST_LOW;
      lcd_rst <= 1'b0;
      dly_cnt <= '0;
      idx     <= '0;
      color   <= BOOT_COLOR;
    end else begin
      case (state)
        S_RST_LOW:
          if (dly_cnt == DLY_W'(T_RST_LOW - 1)) begin
            state   <= S_RST_HIGH;
            lcd_rst <= 1'b1;
            dly_cnt <= '0;
          end else dly_cnt <= dly_cnt + 1'b1;
        S_RST_HIGH:
          if (dly_cnt == DLY_W'(T_RST_HIGH - 1)) begin
            state   <= S_SLPOUT;
            dly_cnt <= '0;
          end else dly_cnt <= dly_cnt + 1'b1;
        S_SLPOUT:
          if (wr_done) state <= S_SLP_WAIT;
        S_SLP_WAIT:
          if (dly_cnt == DLY_W'(T_SLPOUT - 1)) begin
            state   <= S_CFG;
            dly_cnt <= '0;
            idx     <= '0;
          end else dly_cnt <= dly_cnt + 1'b1;
        S_CFG:
          if (wr_done) begin
            if (idx == IDX_W'(CFG_LEN - 1)) begin
              state <= S_WIN;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
        S_WIN:
          if (wr_done) begin
            if (idx == IDX_W'(WIN_LEN - 1)) begin
              state <= S_FILL;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
        S_FILL:
          if (wr_done) begin
            if (idx == IDX_W'(FILL_LEN - 1)) begin
              state <= S_DONE;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
        S_DONE:
          if (fill_req) begin
            color <= fill_color;
            state <= S_WIN;
            idx   <= '0;
          end
        default: begin
          state   <= S_RST_LOW;
          lcd_rst <= 1'b0;
          dly_cnt <= '0;
          idx     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    init_data = 9'h000;
    case (state)
      S_SLPOUT: init_data = 9'h011;
      S_CFG:    init_data = CFG_ROM[idx[5:0]];
      S_WIN:    init_data = WIN_ROM[idx[3:0]];
      S_FILL:   init_data = idx[0] ? {1'b1, color[7:0]} : {1'b1, color[15:8]};
      default:  init_data = 9'h000;
    endcase
    en_write  = |(state & (S_SLPOUT | S_CFG | S_WIN | S_FILL));
    init_done = (state == S_DONE);
    busy      = (state != S_DONE);
  end

endmodule
